reg_op_sequencer: RTL
=====================

// Module: reg_op_sequencer
// PURPOSE
// - Front-end controller for register_file: accepts 9-bit instructions over a valid/ready handshake.
// - Decodes register-class instructions and drives reg_op/reg_src/reg_dst/instr_o for exactly one cycle.
// - Sequences LOAD/STOR through a req/ack data-memory handshake; flushes fetch after branch-class ops.
// - Sits between the instruction fetch unit and register_file; ALU-class instructions pass as 1-cycle NOPs here.
// PARAMETERS
// - TIMEOUT       15  max cycles MEM waits for mem_ack before abort (1..255)
// - FLUSH_CYCLES  2   cycles fetch_flush is held after JIZR/JNZR/BIZR/BNZR (1..15)
// PORTS
// - clk           in   1      system clock; all state updates on posedge
// - rst_n         in   1      synchronous, active-low reset
// - instr_valid   in   1      fetch presents instr
// - instr_ready   out  1      sequencer can accept; transfer = valid & ready at posedge
// - instr         in   9      [8]=1 reg-class: [7:4] reg_OP, [3:0] register field; [8]=0 ALU-class
// - reg_op        out  reg_OP register_file operation; NOP (0) when idle
// - reg_src       out  register source register
// - reg_dst       out  register destination register
// - instr_o       out  4      immediate nibble (instr[3:0]) for LIT_LO/LIT_HI/INCR/DECR
// - mem_req       out  1      data-memory request, held until mem_ack
// - mem_we        out  1      1=store, 0=load; valid while mem_req
// - mem_ack       in   1      memory done; loadData valid in the ack cycle and held through the next cycle
// - fetch_flush   out  1      discard fetched-ahead instructions
// - busy          out  1      ~(state==IDLE)
// - err_timeout   out  1      one-cycle pulse on MEM abort
// - err_illegal   out  1      one-cycle pulse on illegal op
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE, src_latch=4'h0, all outputs 0 (reg_op=NOP), counters 0.
// - Reset mid-operation: same result; mem_req drops the next cycle; no reg_op issued.
// - States: IDLE, ISSUE, MEM, FLUSH, plus a 1-bit "after" register selecting the successor of ISSUE/MEM.
// - IDLE: instr_ready=1; on transfer, decode instr:
//   - ALU-class, or reg_op 0 -> ISSUE with NOP (2-cycle occupancy).
//   - reg_op 1 (SETSRC): src_latch<=instr[3:0], ISSUE with NOP.
//   - reg_op 2, 3, 7 illegal: err_illegal pulse next cycle, stay IDLE.
//   - LIT_LO/LIT_HI/INCR/DECR: reg_dst=field, instr_o=field, then ISSUE.
//   - MOV: reg_src=src_latch, reg_dst=field, then ISSUE.
//   - LOAD: reg_dst=field -> MEM(we=0); after=ISSUE.
//   - STOR: reg_src=field -> ISSUE; after=MEM(we=1).
//   - JIZR/JNZR/BIZR/BNZR: reg_src=field -> ISSUE; after=FLUSH.
// - ISSUE: reg_op valid exactly this cycle (register_file acts on the following negedge).
//   Next state = after-target, else IDLE. instr_ready=0.
// - MEM: mem_req=1, timeout counter counts up from 0.
//   - mem_ack -> LOAD: ISSUE with reg_op=LOAD; STOR: IDLE.
//   - No ack and counter==TIMEOUT-1 -> err_timeout pulse, IDLE, no LOAD issued.
//   - mem_ack in the same cycle as the limit: ack wins, no error.
// - FLUSH: fetch_flush=1 for exactly FLUSH_CYCLES cycles, then IDLE; instr_ready=0 throughout.
// - Outputs are registered; reg_src/reg_dst/instr_o hold their last values outside ISSUE.
// - src_latch persists across instructions until reset or the next SETSRC.
// - Latency: transfer at edge N -> reg_op at cycle N+1; single-cycle op throughput = 1 per 2 cycles.
// - LOAD with ack at cycle K -> reg_op=LOAD at cycle K+1.
// STRUCTURE
// - instr_pack gains:
//   - seq_state_t enum {IDLE, ISSUE, MEM, FLUSH}
//   - REG_CLASS_BIT=8
//   - reg_OP literals 0 NOP, 1 SETSRC, 4 LIT_LO, 5 LIT_HI, 6 MOV, 8 LOAD, 9 STOR,
//     10 INCR, 11 DECR, 12 JIZR, 13 JNZR, 14 BIZR, 15 BNZR
// - Sub-module seq_down_counter (load, enable, zero flag, 8-bit) is shared by the timeout and flush counts.
// - Decode is a combinational function of instr inside this module; a single registered FSM sits around it.
// TESTING
// - Reset: hold rst_n=0 3 cycles with instr_valid=1 -> all outputs 0, instr_ready=0; first cycle after release: instr_ready=1.
// - INCR: instr=9'h1A3 -> next cycle reg_op=INCR, reg_dst=4'h3, instr_o=4'h3 for 1 cycle; instr_ready high again 2 cycles after transfer.
// - SETSRC+MOV: send 9'h118, then 9'h164 -> MOV issued with reg_src=4'h8, reg_dst=4'h4.
// - LOAD: 9'h185, mem_ack after 3 cycles -> mem_req high 4 cycles, mem_we=0; reg_op=LOAD, reg_dst=4'h5 the cycle after ack.
// - LOAD with no ack, TIMEOUT=15 -> mem_req high 15 cycles, then err_timeout pulse, no LOAD, IDLE.
//   Repeat with ack on the 15th cycle -> LOAD issued, no error.
// - BNZR: 9'h1F2 -> reg_op=BNZR, reg_src=4'h2 for 1 cycle, then fetch_flush=1 for 2 cycles.
//   - Illegal op 9'h130 -> err_illegal pulse, no reg_op.
//   - rst_n=0 during MEM -> mem_req=0 the next cycle.

Source files
------------

// File: rtl/reg_op_sequencer_pkg.sv
// Purpose: shared types and constants for the register-file front-end sequencer.
// Contents: instruction field widths, sequencer state enum, reg_OP encodings,
//           and an illegal-opcode helper.
package reg_op_sequencer_pkg;

  localparam int unsigned INSTR_W       = 9;
  localparam int unsigned OP_W          = 4;
  localparam int unsigned REG_W         = 4;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned REG_CLASS_BIT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    MEM   = 2'd2,
    FLUSH = 2'd3
  } seq_state_t;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 4'd0,
    OP_SETSRC = 4'd1,
    OP_LIT_LO = 4'd4,
    OP_LIT_HI = 4'd5,
    OP_MOV    = 4'd6,
    OP_LOAD   = 4'd8,
    OP_STOR   = 4'd9,
    OP_INCR   = 4'd10,
    OP_DECR   = 4'd11,
    OP_JIZR   = 4'd12,
    OP_JNZR   = 4'd13,
    OP_BIZR   = 4'd14,
    OP_BNZR   = 4'd15
  } reg_op_t;

  // Encodings 2, 3 and 7 are unassigned and rejected by the sequencer.
  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return (op == 4'd2) || (op == 4'd3) || (op == 4'd7);
  endfunction

endpackage

// File: rtl/reg_op_sequencer_down_counter.sv
// Purpose: 8-bit loadable down counter with zero flag, shared by the
//          memory-timeout and fetch-flush phases of the sequencer.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_load       load i_load_val (priority over i_enable)
//   i_enable     decrement while non-zero
//   i_load_val   value to load
//   o_zero_c     count is zero (combinational decode of the count register)
module seq_down_counter
  import reg_op_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_count;

  // Saturates at zero so a lingering enable cannot wrap the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/reg_op_sequencer.sv
// Purpose: front-end controller for register_file. Accepts 9-bit instructions
//          over valid/ready, issues one-cycle register ops, sequences LOAD/STOR
//          through a req/ack memory handshake and flushes fetch after branches.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   instr_valid/instr_ready    instruction handshake (transfer = valid & ready)
//   instr[8:0]                 [8]=1 reg-class: [7:4] op, [3:0] register field
//   reg_op/reg_src/reg_dst     register_file command, reg_op valid one cycle
//   instr_o                    immediate nibble for LIT_LO/LIT_HI/INCR/DECR
//   mem_req/mem_we/mem_ack     data-memory handshake
//   fetch_flush                discard fetched-ahead instructions
//   busy                       sequencer not idle
//   err_timeout/err_illegal    one-cycle error pulses
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    reg_op,
  output logic [REG_W-1:0]   reg_src,
  output logic [REG_W-1:0]   reg_dst,
  output logic [REG_W-1:0]   instr_o,
  output logic               mem_req,
  output logic               mem_we,
  input  logic               mem_ack,
  output logic               fetch_flush,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_illegal
);

  // Counter runs down to zero, so load one less than the desired cycle count.
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  seq_state_t       r_state;
  logic             r_after;
  logic [REG_W-1:0] r_src_latch;

  logic             w_xfer;
  logic [OP_W-1:0]  w_op;
  logic [REG_W-1:0] w_field;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_en;
  logic             w_cnt_zero;

  assign w_xfer = instr_valid & instr_ready;

  // Decode: ALU-class instructions collapse to NOP.
  always_comb begin
    w_op    = '0;
    w_field = instr[REG_W-1:0];
    if (instr[REG_CLASS_BIT]) begin
      w_op = instr[REG_W +: OP_W];
    end
  end

  // Counter is loaded on entry to MEM (timeout) or FLUSH (flush length).
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = TO_LOAD;
    if ((r_state == IDLE) && w_xfer && (w_op == OP_LOAD)) begin
      w_cnt_load = 1'b1;
    end else if ((r_state == ISSUE) && r_after) begin
      w_cnt_load = 1'b1;
      if (reg_op != OP_STOR) begin
        w_cnt_val = FL_LOAD;
      end
    end
  end

  assign w_cnt_en = (r_state == MEM) || (r_state == FLUSH);

  seq_down_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_enable   (w_cnt_en),
    .i_load_val (w_cnt_val),
    .o_zero_c   (w_cnt_zero)
  );

  // Sequencer FSM with registered outputs. r_after marks that ISSUE/MEM has a
  // follow-on phase: ISSUE->MEM for STOR, ISSUE->FLUSH for branches,
  // MEM->ISSUE for LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_after     <= 1'b0;
      r_src_latch <= '0;
      instr_ready <= 1'b0;
      reg_op      <= OP_NOP;
      reg_src     <= '0;
      reg_dst     <= '0;
      instr_o     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      fetch_flush <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      err_illegal <= 1'b0;
      unique case (r_state)
        IDLE: begin
          instr_ready <= 1'b1;
          if (w_xfer) begin
            if (op_is_illegal(w_op)) begin
              err_illegal <= 1'b1;
            end else if (w_op == OP_LOAD) begin
              reg_dst     <= w_field;
              mem_req     <= 1'b1;
              mem_we      <= 1'b0;
              r_after     <= 1'b1;
              r_state     <= MEM;
              busy        <= 1'b1;
              instr_ready <= 1'b0;
            end else begin
              reg_op      <= w_op;
              r_after     <= 1'b0;
              r_state     <= ISSUE;
              busy        <= 1'b1;
              instr_ready <= 1'b0;
              case (w_op)
                OP_SETSRC: begin
                  r_src_latch <= w_field;
                  reg_op      <= OP_NOP;
                end
                OP_LIT_LO, OP_LIT_HI, OP_INCR, OP_DECR: begin
                  reg_dst <= w_field;
                  instr_o <= w_field;
                end
                OP_MOV: begin
                  reg_src <= r_src_latch;
                  reg_dst <= w_field;
                end
                OP_STOR, OP_JIZR, OP_JNZR, OP_BIZR, OP_BNZR: begin
                  reg_src <= w_field;
                  r_after <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ISSUE: begin
          reg_op <= OP_NOP;
          if (r_after) begin
            r_after <= 1'b0;
            if (reg_op == OP_STOR) begin
              r_state <= MEM;
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
            end else begin
              r_state     <= FLUSH;
              fetch_flush <= 1'b1;
            end
          end else begin
            r_state     <= IDLE;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
          end
        end
        MEM: begin
          // Ack takes priority over a timeout reached in the same cycle.
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_after <= 1'b0;
            if (r_after) begin
              r_state <= ISSUE;
              reg_op  <= OP_LOAD;
            end else begin
              r_state     <= IDLE;
              busy        <= 1'b0;
              instr_ready <= 1'b1;
            end
          end else if (w_cnt_zero) begin
            mem_req     <= 1'b0;
            r_after     <= 1'b0;
            err_timeout <= 1'b1;
            r_state     <= IDLE;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
          end
        end
        FLUSH: begin
          if (w_cnt_zero) begin
            fetch_flush <= 1'b0;
            r_state     <= IDLE;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
